// File: rtl/keypad_scanner.sv
// +----------------------------------------------------------------------------+
// | Module      : keypad_scanner                                               |
// | Description : 4x4 matrix keypad scanner with full-scan debounce.           |
// |               Drives one column low at a time, samples the active-low      |
// |               rows on the last dwell cycle of each column, collapses a     |
// |               full scan into one snapshot (single key or NONE) and         |
// |               accepts a change after DEBOUNCE_SCANS identical snapshots.   |
// | Parameters  : SCAN_TICKS     - clk cycles each column is driven (>= 2)     |
// |               DEBOUNCE_SCANS - identical snapshots to accept (1..15)       |
// | Ports       : clk       in   system clock, rising edge                     |
// |               rst_n     in   asynchronous active-low reset                 |
// |               col_n     out  column drive, one-hot low                     |
// |               row_n     in   row sense, active-low                         |
// |               key_code  out  hex code of last accepted key                 |
// |               key_valid out  one-cycle strobe on a newly accepted key      |
// |               key_down  out  high while an accepted key is held            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module keypad_scanner #(
   parameter int SCAN_TICKS     = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [3:0] col_n,
   input  logic [3:0] row_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int c_dwell_w = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;

   localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(SCAN_TICKS - 1);
   localparam logic [c_dwell_w-1:0] c_dwell_one  = c_dwell_w'(1);
   localparam logic [3:0]           c_deb        = 4'(DEBOUNCE_SCANS);

   // Snapshot encoding: {valid, key index}; key index = {col, row}, which is
   // also the bit position of that key inside the hits accumulator.
   localparam logic [4:0] c_snap_none = 5'b0_0000;

   // Debounce state machine: accepted NONE or accepted KEY(r_acc_idx)
   localparam logic [0:0] c_st_none = 1'b0;
   localparam logic [0:0] c_st_key  = 1'b1;

   // ------------------------------------------------------------------------
   // Key map: (row, col) -> hex code
   // ------------------------------------------------------------------------
   function automatic logic [3:0] f_key_code(input logic [1:0] row,
                                             input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'h0;
         4'b11_01: code = 4'hF;
         4'b11_10: code = 4'hE;
         default:  code = 4'hD;
      endcase
      return code;
   endfunction

   // ------------------------------------------------------------------------
   // Signals
   // ------------------------------------------------------------------------
   logic [c_dwell_w-1:0] r_dwell;
   logic [1:0]           r_col_idx;
   logic [1:0]           w_col_idx_nxt;
   logic [3:0]           r_col_n;
   logic [15:0]          r_hits;
   logic [15:0]          w_hits_full;
   logic                 w_sample;
   logic                 w_scan_end;

   logic [4:0]           w_ones;
   logic [3:0]           w_idx;
   logic [4:0]           w_snap;

   logic [4:0]           r_prev_snap;
   logic [3:0]           r_stable_cnt;
   logic [3:0]           w_stable_nxt;
   logic [4:0]           w_acc_snap;
   logic                 w_accept;

   logic [0:0]           r_state;
   logic [0:0]           w_state_nxt;
   logic [3:0]           r_acc_idx;
   logic [3:0]           r_key_code;
   logic                 r_key_valid;

   // ------------------------------------------------------------------------
   // Scan sequencer
   // ------------------------------------------------------------------------
   assign w_sample      = (r_dwell == c_dwell_last);
   assign w_scan_end    = w_sample && (r_col_idx == 2'd3);
   assign w_col_idx_nxt = r_col_idx + 2'd1;

   // Column drive is registered so the pins never glitch while the index
   // changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dwell   <= '0;
         r_col_idx <= 2'd0;
         r_col_n   <= 4'b1110;
      end else if (w_sample) begin
         r_dwell   <= '0;
         r_col_idx <= w_col_idx_nxt;
         r_col_n   <= ~(4'b0001 << w_col_idx_nxt);
      end else begin
         r_dwell   <= r_dwell + c_dwell_one;
      end
   end

   assign col_n = r_col_n;

   // ------------------------------------------------------------------------
   // Hits accumulator: rows stored inverted at bits [col*4 +: 4]. The last
   // column is never stored; it is merged combinationally at scan end and
   // the accumulator cleared in the same edge.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hits <= '0;
      end else if (w_sample) begin
         if (r_col_idx == 2'd3) begin
            r_hits <= '0;
         end else begin
            r_hits[{r_col_idx, 2'b00} +: 4] <= ~row_n;
         end
      end
   end

   assign w_hits_full = r_hits | {~row_n, 12'h000};

   // ------------------------------------------------------------------------
   // Snapshot: exactly one hit gives that key, anything else is NONE, so
   // ghosting and multi-press can never produce a key.
   // ------------------------------------------------------------------------
   always_comb begin
      w_ones = 5'd0;
      w_idx  = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (w_hits_full[i]) begin
            w_ones = w_ones + 5'd1;
            w_idx  = 4'(i);
         end
      end
      w_snap = (w_ones == 5'd1) ? {1'b1, w_idx} : c_snap_none;
   end

   // ------------------------------------------------------------------------
   // Debounce counter
   // ------------------------------------------------------------------------
   always_comb begin
      w_stable_nxt = 4'd1;
      if (w_snap == r_prev_snap) begin
         w_stable_nxt = (r_stable_cnt >= c_deb) ? c_deb : (r_stable_cnt + 4'd1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev_snap  <= c_snap_none;
         r_stable_cnt <= 4'd0;
      end else if (w_scan_end) begin
         r_prev_snap  <= w_snap;
         r_stable_cnt <= w_stable_nxt;
      end
   end

   assign w_acc_snap = (r_state == c_st_key) ? {1'b1, r_acc_idx} : c_snap_none;
   assign w_accept   = w_scan_end && (w_stable_nxt == c_deb) && (w_snap != w_acc_snap);

   // ------------------------------------------------------------------------
   // Accepted-key FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_none;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic. A key-to-key change stays in KEY; only the stored
   // index moves.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_none: if (w_accept && w_snap[4])  w_state_nxt = c_st_key;
         c_st_key:  if (w_accept && !w_snap[4]) w_state_nxt = c_st_none;
         default:   w_state_nxt = c_st_none;
      endcase
   end

   // Output decode
   always_comb begin
      key_down = (r_state == c_st_key);
   end

   // Accepted key index, code and strobe. Releasing to NONE leaves the code
   // untouched so downstream keeps showing the last key.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc_idx   <= 4'd0;
         r_key_code  <= 4'd0;
         r_key_valid <= 1'b0;
      end else begin
         r_key_valid <= w_accept && w_snap[4];
         if (w_accept && w_snap[4]) begin
            r_acc_idx  <= w_snap[3:0];
            r_key_code <= f_key_code(w_snap[1:0], w_snap[3:2]);
         end
      end
   end

   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;

endmodule

`default_nettype wire
